// File: rtl/harvos_pkg.sv
// Shared privilege, mtvec-mode and trap/return sequencer types for the
// machine-mode trap path.
package harvos_pkg;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_M = 2'b11
   } priv_e;

   localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

   typedef enum logic {
      TR_IDLE,
      TR_REDIRECT
   } tr_state_e;

endpackage

// File: rtl/trap_vector_calc.sv
// Trap target from a tvec CSR and cause; vectored mode applies to interrupts only,
// reserved MODE values fall back to direct.
module trap_vector_calc
   import harvos_pkg::*;
#(
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic [31:0] tvec,
   input  logic [31:0] cause,
   output logic [31:0] target
);

   logic [31:0] base;
   logic [31:0] ofs;
   logic        use_vec;

   assign base    = tvec & 32'hFFFF_FFFC;
   // cause[30:0]<<2 overflows into bit 32; the wrap is intentional
   assign ofs     = 32'({cause[30:0], 2'b00});
   assign use_vec = VECTORED_EN && (tvec[1:0] == MTVEC_MODE_VECTORED) && cause[31];
   assign target  = use_vec ? (base + ofs) : base;

endmodule

// File: rtl/trap_return_ctrl.sv
// Machine-mode trap entry / MRET sequencer: owns privilege, mstatus.{MIE,MPIE,MPP},
// mepc and mcause, and hands a PC redirect plus flush to fetch over valid/ready.
module trap_return_ctrl
   import harvos_pkg::*;
#(
   parameter bit HAS_U_MODE  = 1'b1,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mret_pulse,
   input  logic        trap_req,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_pc,
   input  logic [31:0] mtvec,
   input  logic        csr_mepc_we,
   input  logic [31:0] csr_wdata,
   output logic        trap_ack,
   output logic        busy,
   output logic        redir_valid,
   output logic [31:0] redir_pc,
   input  logic        redir_ready,
   output logic        flush,
   output priv_e       cur_priv,
   output logic        mstatus_mie,
   output logic        mstatus_mpie,
   output logic [1:0]  mstatus_mpp,
   output logic [31:0] mepc,
   output logic [31:0] mcause
);

   tr_state_e   state_q, state_d;
   logic        mret_acc;
   logic [31:0] trap_target;

   trap_vector_calc #(.VECTORED_EN(VECTORED_EN)) u_vec (
      .tvec   (mtvec),
      .cause  (trap_cause),
      .target (trap_target)
   );

   // Trap has priority over a coincident MRET; both are ignored while redirecting.
   always_comb begin
      state_d  = state_q;
      trap_ack = 1'b0;
      mret_acc = 1'b0;
      case (state_q)
         TR_IDLE: begin
            trap_ack = trap_req;
            mret_acc = !trap_req && mret_pulse && (cur_priv == PRIV_M);
            if (trap_req || mret_acc)
               state_d = TR_REDIRECT;
         end
         TR_REDIRECT: begin
            if (redir_ready)
               state_d = TR_IDLE;
         end
         default: state_d = TR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= TR_IDLE;
      else
         state_q <= state_d;
   end

   assign busy        = (state_q == TR_REDIRECT);
   assign redir_valid = busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_priv     <= PRIV_M;
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mstatus_mpp  <= PRIV_M;
         mepc         <= '0;
         mcause       <= '0;
         redir_pc     <= '0;
         flush        <= 1'b0;
      end else begin
         flush <= 1'b0;
         if (trap_ack) begin
            mepc         <= trap_pc & 32'hFFFF_FFFC;
            mcause       <= trap_cause;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            mstatus_mpp  <= cur_priv;
            cur_priv     <= PRIV_M;
            redir_pc     <= trap_target;
            flush        <= 1'b1;
         end else if (mret_acc) begin
            cur_priv     <= priv_e'(mstatus_mpp);
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            mstatus_mpp  <= HAS_U_MODE ? PRIV_U : PRIV_M;
            redir_pc     <= mepc;
            flush        <= 1'b1;
         end else if (csr_mepc_we) begin
            mepc <= csr_wdata & 32'hFFFF_FFFC;
         end
      end
   end

endmodule

// File: tb/tb_trap_return_ctrl.sv
// Two configurations (U-mode+vectored, M-only+direct) driven in lockstep and
// compared every cycle against a transaction-level model of the trap/MRET rules.
module tb_trap_return_ctrl;
   import harvos_pkg::*;

   logic        clk = 1'b0;
   logic        rst, mret_pulse, trap_req, csr_mepc_we, redir_ready;
   logic [31:0] trap_cause, trap_pc, mtvec, csr_wdata;

   logic        a_ack, a_busy, a_rv, a_flush, a_mie, a_mpie;
   logic [31:0] a_rpc, a_mepc, a_mcause;
   logic [1:0]  a_mpp;
   priv_e       a_priv;
   logic        b_ack, b_busy, b_rv, b_flush, b_mie, b_mpie;
   logic [31:0] b_rpc, b_mepc, b_mcause;
   logic [1:0]  b_mpp;
   priv_e       b_priv;

   always #5 clk = ~clk;

   trap_return_ctrl #(.HAS_U_MODE(1'b1), .VECTORED_EN(1'b1)) dut_a (
      .clk(clk), .rst(rst), .mret_pulse(mret_pulse), .trap_req(trap_req),
      .trap_cause(trap_cause), .trap_pc(trap_pc), .mtvec(mtvec),
      .csr_mepc_we(csr_mepc_we), .csr_wdata(csr_wdata), .trap_ack(a_ack),
      .busy(a_busy), .redir_valid(a_rv), .redir_pc(a_rpc), .redir_ready(redir_ready),
      .flush(a_flush), .cur_priv(a_priv), .mstatus_mie(a_mie), .mstatus_mpie(a_mpie),
      .mstatus_mpp(a_mpp), .mepc(a_mepc), .mcause(a_mcause));

   trap_return_ctrl #(.HAS_U_MODE(1'b0), .VECTORED_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst), .mret_pulse(mret_pulse), .trap_req(trap_req),
      .trap_cause(trap_cause), .trap_pc(trap_pc), .mtvec(mtvec),
      .csr_mepc_we(csr_mepc_we), .csr_wdata(csr_wdata), .trap_ack(b_ack),
      .busy(b_busy), .redir_valid(b_rv), .redir_pc(b_rpc), .redir_ready(redir_ready),
      .flush(b_flush), .cur_priv(b_priv), .mstatus_mie(b_mie), .mstatus_mpie(b_mpie),
      .mstatus_mpp(b_mpp), .mepc(b_mepc), .mcause(b_mcause));

   typedef struct {
      bit          busy;
      bit          flush;
      logic [31:0] rpc;
      logic [1:0]  priv;
      bit          mie, mpie;
      logic [1:0]  mpp;
      logic [31:0] mepc, mcause;
   } mdl_t;

   mdl_t ma, mb;
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] tgt(input logic [31:0] tv, input logic [31:0] cause,
                                       input bit vec);
      logic [31:0] base = tv - (tv % 4);
      if (vec && (tv % 4) == 1 && cause >= 32'h8000_0000)
         return base + (cause - 32'h8000_0000) * 4;
      return base;
   endfunction

   function automatic mdl_t mdl_next(input mdl_t s, input bit hasu, input bit vec);
      mdl_t n = s;
      if (rst) begin
         n = '{busy: 0, flush: 0, rpc: 0, priv: 2'd3, mie: 0, mpie: 0, mpp: 2'd3,
               mepc: 0, mcause: 0};
         return n;
      end
      n.flush = 0;
      if (s.busy) begin
         if (csr_mepc_we) n.mepc = csr_wdata - (csr_wdata % 4);
         if (redir_ready) n.busy = 0;
      end else if (trap_req) begin
         n.mepc   = trap_pc - (trap_pc % 4);
         n.mcause = trap_cause;
         n.mpie   = s.mie;
         n.mie    = 0;
         n.mpp    = s.priv;
         n.priv   = 2'd3;
         n.rpc    = tgt(mtvec, trap_cause, vec);
         n.busy   = 1;
         n.flush  = 1;
      end else if (mret_pulse && s.priv == 2'd3) begin
         n.priv  = s.mpp;
         n.mie   = s.mpie;
         n.mpie  = 1;
         n.mpp   = hasu ? 2'd0 : 2'd3;
         n.rpc   = s.mepc;
         n.busy  = 1;
         n.flush = 1;
      end else if (csr_mepc_we) begin
         n.mepc = csr_wdata - (csr_wdata % 4);
      end
      return n;
   endfunction

   task automatic chk_all(input string w, input mdl_t m, input logic busy, input logic rv,
                          input logic [31:0] rpc, input logic flush, input logic [1:0] priv,
                          input logic mie, input logic mpie, input logic [1:0] mpp,
                          input logic [31:0] mepc, input logic [31:0] mcause);
      chk({w, ".busy"}, 32'(busy), 32'(m.busy));
      chk({w, ".redir_valid"}, 32'(rv), 32'(m.busy));
      if (m.busy) chk({w, ".redir_pc"}, rpc, m.rpc);
      chk({w, ".flush"}, 32'(flush), 32'(m.flush));
      chk({w, ".priv"}, 32'(priv), 32'(m.priv));
      chk({w, ".mie"}, 32'(mie), 32'(m.mie));
      chk({w, ".mpie"}, 32'(mpie), 32'(m.mpie));
      chk({w, ".mpp"}, 32'(mpp), 32'(m.mpp));
      chk({w, ".mepc"}, mepc, m.mepc);
      chk({w, ".mcause"}, mcause, m.mcause);
   endtask

   // Inputs are driven 1 time unit after posedge; ack is sampled on the negedge.
   task automatic cyc();
      @(negedge clk);
      if (!rst) begin
         chk("a.trap_ack", 32'(a_ack), 32'(!ma.busy && trap_req));
         chk("b.trap_ack", 32'(b_ack), 32'(!mb.busy && trap_req));
      end
      @(posedge clk);
      ma = mdl_next(ma, 1'b1, 1'b1);
      mb = mdl_next(mb, 1'b0, 1'b0);
      #1;
      chk_all("a", ma, a_busy, a_rv, a_rpc, a_flush, a_priv, a_mie, a_mpie, a_mpp, a_mepc, a_mcause);
      chk_all("b", mb, b_busy, b_rv, b_rpc, b_flush, b_priv, b_mie, b_mpie, b_mpp, b_mepc, b_mcause);
   endtask

   task automatic quiet(input logic rdy);
      rst = 0; trap_req = 0; mret_pulse = 0; csr_mepc_we = 0; redir_ready = rdy;
   endtask

   task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tv);
      quiet(1'b0);
      trap_req = 1; trap_cause = cause; trap_pc = pc; mtvec = tv;
      cyc();
   endtask

   task automatic do_mret();
      quiet(1'b0);
      mret_pulse = 1;
      cyc();
   endtask

   task automatic drain();
      quiet(1'b1);
      cyc();
   endtask

   initial begin
      quiet(1'b0);
      rst = 1; trap_cause = 0; trap_pc = 0; mtvec = 0; csr_wdata = 0;
      cyc(); cyc();
      chk("rst.priv", 32'(a_priv), 32'h3);
      chk("rst.redir_valid", 32'(a_rv), 32'h0);

      do_trap(32'h2, 32'h0000_1006, 32'h0000_0100);
      chk("tp1.mepc", a_mepc, 32'h1004);
      chk("tp1.mcause", a_mcause, 32'h2);
      chk("tp1.redir_pc", a_rpc, 32'h100);
      chk("tp1.flush", 32'(a_flush), 32'h1);
      drain();

      do_trap(32'h8000_0007, 32'h0000_0040, 32'h0000_0201);
      chk("tp2.vec_pc", a_rpc, 32'h21C);
      chk("tp2.direct_pc", b_rpc, 32'h200);
      drain();

      do_mret(); drain();
      do_mret(); drain();
      chk("tp3.in_u", 32'(a_priv), 32'h0);
      chk("tp3.mie_u", 32'(a_mie), 32'h1);
      do_trap(32'h3, 32'h0000_0400, 32'h0000_0100); drain();
      quiet(1'b0); csr_mepc_we = 1; csr_wdata = 32'h2000; cyc();
      do_mret();
      chk("tp3.priv", 32'(a_priv), 32'h0);
      chk("tp3.mie", 32'(a_mie), 32'h1);
      chk("tp3.mpie", 32'(a_mpie), 32'h1);
      chk("tp3.mpp", 32'(a_mpp), 32'h0);
      chk("tp3.redir_pc", a_rpc, 32'h2000);
      drain();

      quiet(1'b0);
      trap_req = 1; mret_pulse = 1; trap_cause = 32'h5; trap_pc = 32'h88; mtvec = 32'h300;
      cyc();
      chk("tp4.redir_pc", a_rpc, 32'h300);
      chk("tp4.mpp", 32'(a_mpp), 32'h0);
      drain();

      do_trap(32'hB, 32'h0000_0500, 32'h0000_0100);
      for (int i = 0; i < 5; i++) begin
         quiet(1'b0); trap_req = 1; trap_cause = 32'h4; mtvec = 32'h700;
         cyc();
         chk("tp5.busy", 32'(a_busy), 32'h1);
         chk("tp5.redir_pc", a_rpc, 32'h100);
         chk("tp5.mcause", a_mcause, 32'hB);
      end
      drain();
      chk("tp5.idle", 32'(a_busy), 32'h0);

      do_trap(32'h1, 32'h0000_0600, 32'h0000_0100);
      quiet(1'b0); rst = 1; cyc();
      chk("tp6.rv", 32'(a_rv), 32'h0);
      chk("tp6.mepc", a_mepc, 32'h0);
      quiet(1'b0); csr_mepc_we = 1; csr_wdata = 32'h3003; cyc();
      chk("tp6.csr_mepc", a_mepc, 32'h3000);

      for (int i = 0; i < 1500; i++) begin
         rst         = ($urandom_range(0, 79) == 0);
         trap_req    = ($urandom_range(0, 3) == 0);
         mret_pulse  = ($urandom_range(0, 2) == 0);
         csr_mepc_we = ($urandom_range(0, 5) == 0);
         redir_ready = ($urandom_range(0, 1) == 0);
         csr_wdata   = $urandom;
         trap_pc     = $urandom;
         mtvec       = $urandom;
         trap_cause  = $urandom_range(0, 1) ? $urandom : {$urandom_range(0, 1) ? 1'b1 : 1'b0,
                                                          31'($urandom_range(0, 15))};
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/trap_return_ctrl.md
Name: trap_return_ctrl

Overview:
- Privilege and trap-state sequencer directly downstream of the MRET decoder.
- Consumes the decoder's 1-cycle MRET pulse and the pipeline's trap requests.
- Owns cur_priv, mstatus.{MIE,MPIE,MPP}, mepc and mcause, and issues a PC redirect plus flush to fetch through a valid/ready handshake.
- Its cur_priv output feeds back to the MRET decoder's privilege input.

Parameters:
- HAS_U_MODE, 1, when 1 MRET sets MPP to PRIV_U; when 0 MRET sets MPP to PRIV_M.
- VECTORED_EN, 1, when 1 honour mtvec.MODE==1 for interrupts; when 0 always use direct mode.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- mret_pulse  in  1  valid-MRET pulse from the decoder
- trap_req  in  1  exception/interrupt request, held until accepted
- trap_cause  in  32  mcause value; bit31=interrupt
- trap_pc  in  32  PC of the faulting/interrupted instruction
- mtvec  in  32  from CSR file; [1:0]=MODE, [31:2]=BASE
- csr_mepc_we  in  1  software write to mepc
- csr_wdata  in  32  write data
- trap_ack  out  1  trap_req accepted this cycle (combinational)
- busy  out  1  redirect outstanding; upstream must stall
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  32  redirect target, stable while redir_valid
- redir_ready  in  1  fetch accepts the redirect
- flush  out  1  1-cycle pipeline flush
- cur_priv  out  2 (priv_e)  current privilege
- mstatus_mie, mstatus_mpie  out  1 each
- mstatus_mpp  out  2  previous privilege
- mepc, mcause  out  32 each

Behaviour:
- Reset (synchronous, rst=1 at posedge): cur_priv=PRIV_M, MIE=0, MPIE=0, MPP=PRIV_M, mepc=0, mcause=0, redir_valid=0, redir_pc=0, flush=0, busy=0. State=IDLE.
- FSM states are IDLE and REDIRECT. busy=(state==REDIRECT).
- IDLE, accepting an event at cycle N: all state updates, plus redir_valid=1, flush=1 and state=REDIRECT, are visible at N+1.
- REDIRECT: hold redir_valid and redir_pc. Leave to IDLE on the edge where redir_valid&&redir_ready. flush is high only in the first REDIRECT cycle. A ready in that first cycle is legal, giving one-cycle REDIRECT.
- Events arriving in REDIRECT are ignored: trap_ack=0 and no state change. MRET pulses are lost; the upstream stall on busy prevents them.
- trap_ack = (state==IDLE) && trap_req.
- Trap accept:
  - mepc = {trap_pc[31:2],2'b00}
  - mcause = trap_cause
  - MPIE = MIE; MIE = 0; MPP = cur_priv; cur_priv = PRIV_M
  - redir_pc = target (see below)
- Target:
  - BASE = {mtvec[31:2],2'b00}.
  - If VECTORED_EN && mtvec[1:0]==2'b01 && trap_cause[31]: target = BASE + (trap_cause[30:0]<<2), truncated to 32 bits (wrap allowed).
  - Otherwise target = BASE. mtvec MODE values 2/3 are treated as direct.
- MRET accept: requires mret_pulse && cur_priv==PRIV_M; a pulse in a lower privilege is ignored defensively.
  - cur_priv = MPP; MIE = MPIE; MPIE = 1
  - MPP = HAS_U_MODE ? PRIV_U : PRIV_M
  - redir_pc = mepc (value before this edge)
- Simultaneous trap_req and mret_pulse: trap wins and the MRET is dropped.
- csr_mepc_we: mepc = {csr_wdata[31:2],2'b00}, applied only when no event is accepted that cycle; a trap overrides it. In REDIRECT the write is applied.
- Reset mid-REDIRECT: immediate return to reset values; the outstanding redirect is abandoned (redir_valid=0 the next cycle).

Decomposition:
- harvos_pkg: priv_e (PRIV_U=2'b00, PRIV_M=2'b11), the MTVEC_MODE_DIRECT/VECTORED constants, and a tr_state_e enum {TR_IDLE, TR_REDIRECT}.
- One combinational sub-module, trap_vector_calc (mtvec, cause, VECTORED_EN -> target), shared with a future S-mode stvec path.

Test Plan:
- Reset, then trap_req with cause=0x2, trap_pc=0x0000_1006, mtvec=0x0000_0100 -> trap_ack=1. Next cycle: mepc=0x1004, mcause=0x2, cur_priv=M, MIE=0, redir_pc=0x100, redir_valid=1, flush=1.
- Interrupt cause=0x8000_0007 with mtvec=0x0000_0201 -> redir_pc=0x21C. Repeat with VECTORED_EN=0 -> 0x200.
- MIE=1 in U mode, trap, then MRET with mepc=0x2000 -> after the MRET: cur_priv=U, MIE=1, MPIE=1, MPP=U, redir_pc=0x2000.
- trap_req and mret_pulse in the same cycle -> trap path only: redir_pc=mtvec base, MPP=previous priv.
- Hold redir_ready=0 for 5 cycles -> redir_valid and redir_pc stable, busy=1, flush high 1 cycle only, a trap_req meanwhile gets trap_ack=0. Raise ready -> IDLE next cycle.
- Assert rst during REDIRECT -> next cycle redir_valid=0, cur_priv=M, mepc=0. A csr_mepc_we with data 0x3003 in IDLE -> mepc=0x3000.
